// File: rtl/board_input_conditioner_pkg.sv
// board_io_pkg: shared constants and helpers for the board input conditioner.
//   cnt_width(n)         - counter width able to hold 0..n-1, never below 1 bit
//   DEFAULT_RESET_CYCLES - default length of the stretched power-up/request reset
package board_io_pkg;

    localparam int unsigned DEFAULT_RESET_CYCLES = 16;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/board_input_conditioner_if.sv
// board_input_conditioner_if: pin-side and core-side signals of the conditioner.
//   raw_in    - asynchronous pin levels (NUM_INPUTS)
//   sys_reset - stretched active-high reset for downstream logic
//   level     - debounced active-high input state (NUM_INPUTS)
//   rise/fall - one-cycle edge pulses of level (NUM_INPUTS)
// master: board/core side (drives pins, observes conditioned outputs)
// slave : conditioner side
interface board_input_conditioner_if #(
    parameter int unsigned NUM_INPUTS = 1
);
    logic [NUM_INPUTS-1:0] raw_in;
    logic                  sys_reset;
    logic [NUM_INPUTS-1:0] level;
    logic [NUM_INPUTS-1:0] rise;
    logic [NUM_INPUTS-1:0] fall;

    modport master (
        output raw_in,
        input  sys_reset,
        input  level,
        input  rise,
        input  fall
    );

    modport slave (
        input  raw_in,
        output sys_reset,
        output level,
        output rise,
        output fall
    );
endinterface

// File: rtl/board_input_conditioner_channel.sv
// input_conditioner_channel: one input bit - synchroniser, polarity correction,
// debounce and edge detection.
//   clock   - sole clock
//   clear_i - synchronous clear (external reset or stretched reset active)
//   pin_i   - asynchronous pin level
//   level_o - debounced active-high state
//   rise_o  - one-cycle pulse on level 0->1
//   fall_o  - one-cycle pulse on level 1->0
module input_conditioner_channel
    import board_io_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 3,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic clock,
    input  logic clear_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned   CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pin_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (synced == level_q) begin
            // Any return to the accepted level, however brief, restarts the count.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = synced;
            cnt_d   = '0;
            rise_d  = synced;
            fall_d  = ~synced;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear_i) begin
            // Sync chain parks at the inactive pin level so release produces no edge
            // unless the pin is actually active.
            sync_q  <= {SYNC_STAGES{ACTIVE_LOW}};
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

// File: rtl/board_input_conditioner.sv
// board_input_conditioner: stretched system reset plus NUM_INPUTS conditioned inputs.
//   clock - sole clock
//   reset - synchronous active-high request for a new reset sequence
//   io    - slave side of board_input_conditioner_if
//           (raw_in in; sys_reset, level, rise, fall out)
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned           NUM_INPUTS      = 1,
    parameter int unsigned           SYNC_STAGES     = 3,
    parameter logic [NUM_INPUTS-1:0] ACTIVE_LOW_MASK = '1,
    parameter int unsigned           DEBOUNCE_CYCLES = 1,
    parameter int unsigned           RESET_CYCLES    = DEFAULT_RESET_CYCLES
) (
    input  logic                      clock,
    input  logic                      reset,
    board_input_conditioner_if.slave  io
);
    localparam int unsigned    RCW      = $clog2(RESET_CYCLES + 1);
    localparam logic [RCW-1:0] RST_LOAD = RCW'(RESET_CYCLES);

    // Power-up value comes from the register initialiser: there is no reset
    // pin to rely on before the stretcher itself has run.
    logic [RCW-1:0]        rst_cnt_q = RST_LOAD;
    logic [RCW-1:0]        rst_cnt_d;
    logic                  sys_reset;
    logic                  clear;
    logic [NUM_INPUTS-1:0] level_w, rise_w, fall_w;

    always_comb begin
        rst_cnt_d = rst_cnt_q;
        if (reset) begin
            rst_cnt_d = RST_LOAD;
        end else if (rst_cnt_q != '0) begin
            rst_cnt_d = rst_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        rst_cnt_q <= rst_cnt_d;
    end

    assign sys_reset = (rst_cnt_q != '0);
    assign clear     = reset | sys_reset;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_chan
        input_conditioner_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[i]),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clock   (clock),
            .clear_i (clear),
            .pin_i   (io.raw_in[i]),
            .level_o (level_w[i]),
            .rise_o  (rise_w[i]),
            .fall_o  (fall_w[i])
        );
    end

    assign io.sys_reset = sys_reset;
    assign io.level     = level_w;
    assign io.rise      = rise_w;
    assign io.fall      = fall_w;
endmodule

// File: tb/tb_board_input_conditioner.sv
// Directed bench for board_input_conditioner.
// dut_a: 2 channels, mask 2'b01, S=3, D=1, R=16 (power-up, runtime reset, edges,
//        held input through reset).
// dut_b: 1 active-low channel, S=3, D=8, R=16 (glitch, long hold, reset mid-count).
// Edge e below means "state observed 1 time unit after the e-th rising edge";
// stimulus set after edge e is first sampled at edge e+1.
module tb_board_input_conditioner;
    logic clock   = 1'b0;
    logic reset_a = 1'b0;
    logic reset_b = 1'b0;
    int   edge_n  = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    board_input_conditioner_if #(.NUM_INPUTS(2)) io_a ();
    board_input_conditioner_if #(.NUM_INPUTS(1)) io_b ();

    board_input_conditioner #(
        .NUM_INPUTS      (2),
        .SYNC_STAGES     (3),
        .ACTIVE_LOW_MASK (2'b01),
        .DEBOUNCE_CYCLES (1),
        .RESET_CYCLES    (16)
    ) dut_a (
        .clock (clock),
        .reset (reset_a),
        .io    (io_a)
    );

    board_input_conditioner #(
        .NUM_INPUTS      (1),
        .SYNC_STAGES     (3),
        .ACTIVE_LOW_MASK (1'b1),
        .DEBOUNCE_CYCLES (8),
        .RESET_CYCLES    (16)
    ) dut_b (
        .clock (clock),
        .reset (reset_b),
        .io    (io_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        edge_n++;
        #1;
    endtask

    function automatic logic [31:0] in_rng(input int e, input int lo, input int hi);
        return 32'((e >= lo) && (e <= hi));
    endfunction

    // Hand-derived expectations for dut_a.
    function automatic logic [31:0] exp_sysrst_a(input int e);
        return 32'((e < 16) || (in_rng(e, 40, 55) != 0) || (in_rng(e, 80, 105) != 0)
                   || (in_rng(e, 150, 167) != 0));
    endfunction

    function automatic logic [31:0] exp_level_a(input int e);
        if (in_rng(e, 123, 132) != 0) return 32'h3;
        if (in_rng(e, 143, 149) != 0) return 32'h1;
        if (e >= 172)                 return 32'h1;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_rise_a(input int e);
        if (e == 123) return 32'h3;
        if (e == 143) return 32'h1;
        if (e == 172) return 32'h1;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_fall_a(input int e);
        return (e == 133) ? 32'h3 : 32'h0;
    endfunction

    // Hand-derived expectations for dut_b.
    function automatic logic [31:0] exp_sysrst_b(input int e);
        return 32'((e < 16) || (in_rng(e, 265, 280) != 0));
    endfunction

    initial begin
        io_a.raw_in = 2'b01;   // both channels inactive
        io_b.raw_in = 1'b1;    // inactive (active-low)
        #1;
        check_eq("sys_reset_a_pwrup", 32'(io_a.sys_reset), 32'h1);
        check_eq("sys_reset_b_pwrup", 32'(io_b.sys_reset), 32'h1);
        check_eq("level_a_pwrup",     32'(io_a.level),     32'h0);

        for (int e = 1; e <= 300; e++) begin
            step();
            check_eq("sys_reset_a", 32'(io_a.sys_reset), exp_sysrst_a(e));
            check_eq("level_a",     32'(io_a.level),     exp_level_a(e));
            check_eq("rise_a",      32'(io_a.rise),      exp_rise_a(e));
            check_eq("fall_a",      32'(io_a.fall),      exp_fall_a(e));
            check_eq("sys_reset_b", 32'(io_b.sys_reset), exp_sysrst_b(e));
            check_eq("level_b",     32'(io_b.level),     in_rng(e, 230, 249));
            check_eq("rise_b",      32'(io_b.rise),      32'(e == 230));
            check_eq("fall_b",      32'(io_b.fall),      32'(e == 250));

            case (e)
                39, 79, 89, 149: reset_a = 1'b1;
                40, 80, 90, 152: reset_a = 1'b0;
                default: ;
            endcase
            case (e)
                119: io_a.raw_in = 2'b10;  // both active
                129: io_a.raw_in = 2'b01;  // both inactive
                139: io_a.raw_in = 2'b00;  // only channel 0 active
                default: ;
            endcase
            case (e)
                199, 219, 259: io_b.raw_in = 1'b0;
                204, 239, 265: io_b.raw_in = 1'b1;
                default: ;
            endcase
            case (e)
                264: reset_b = 1'b1;
                265: reset_b = 1'b0;
                default: ;
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/board_input_conditioner.md
# board_input_conditioner

Board-level reset and input conditioning block for the Tang Nano 9K designs. It generates a stretched system reset at power-up and on request, and conditions `NUM_INPUTS` asynchronous buttons or switches. Each input passes through a synchroniser, a per-bit polarity correction, a debouncer and an edge detector. It sits between the board pins and the application core (e.g. `LifeGameFram`), replacing ad-hoc reset shift registers and 3-flop button synchronisers in each design's top.

## Interface
Parameters:
- `NUM_INPUTS`, default 1: number of conditioned input channels (≥1).
- `SYNC_STAGES`, default 3: synchroniser flops per channel (≥2).
- `ACTIVE_LOW_MASK`, default `'1` (`NUM_INPUTS` bits): bit i = 1 means pin i is active-low and is inverted.
- `DEBOUNCE_CYCLES`, default 1: consecutive cycles a new value must persist before it is accepted (≥1; 1 = no debounce).
- `RESET_CYCLES`, default 16: length of the stretched reset (≥1).

Ports:
- `clock`, input, 1: sole clock.
- `reset`, input, 1: synchronous, active-high; requests a new reset sequence.
- `raw_in`, input, `NUM_INPUTS`: asynchronous pin levels.
- `sys_reset`, output, 1: stretched synchronous active-high reset for downstream logic.
- `level`, output, `NUM_INPUTS`: debounced, active-high input state.
- `rise`, output, `NUM_INPUTS`: one-cycle pulse when `level[i]` goes 0→1.
- `fall`, output, `NUM_INPUTS`: one-cycle pulse when `level[i]` goes 1→0.

## Operation
- Reset stretcher:
  - Down-counter `rst_cnt`, width `$clog2(RESET_CYCLES+1)`, power-up value `RESET_CYCLES` via initial value.
  - Any edge with `reset`=1 reloads `RESET_CYCLES`; otherwise it decrements while nonzero.
  - `sys_reset` = (`rst_cnt` != 0), decoded from the register.
- Channel clear: applies when `reset` || `sys_reset`.
  - Sync flops load the inactive pin value (`ACTIVE_LOW_MASK[i]`).
  - `level`, `rise`, `fall` and the debounce counter go to 0.
- Channel pipeline per bit i:
  - `SYNC_STAGES` flops feed `synced` = `last stage ^ ACTIVE_LOW_MASK[i]`.
  - Debounce counter width `$clog2(DEBOUNCE_CYCLES)` (min 1).
  - If `synced` == `level`: counter ← 0.
  - Else if counter == `DEBOUNCE_CYCLES-1`: `level` ← `synced`, counter ← 0, and `rise` or `fall` is asserted for exactly that cycle.
  - Else: counter ← counter+1.
- Glitch handling: a glitch shorter than `DEBOUNCE_CYCLES` cycles at the synchroniser output clears the counter and produces no output change.
- Channels are fully independent; simultaneous edges on several channels each pulse in the same cycle.
- `rise` and `fall` of one channel are never both high.

## Timing
- Power-up: `sys_reset`=1 for edges 0..`RESET_CYCLES`-1, and 0 from the cycle after the `RESET_CYCLES`-th edge.
- Runtime reset:
  - `sys_reset` goes high on the edge that samples `reset`=1.
  - It stays high while `reset` is held.
  - It falls exactly `RESET_CYCLES` edges after the first edge sampling `reset`=0.
- Reset mid-operation:
  - Asserting `reset` during a running sequence restarts it from `RESET_CYCLES`.
  - Asserting it during a debounce count discards the count with no pulse.
- Input latency: a clean pin change sampled at edge 1 appears on `level` and `rise`/`fall` after edge `SYNC_STAGES+DEBOUNCE_CYCLES`. With defaults (3, 1) that is edge 4, matching the legacy 3-flop path.
- Pin held active through reset release:
  - `level` rises `SYNC_STAGES+DEBOUNCE_CYCLES` edges after `sys_reset` deasserts.
  - A `rise` pulse is emitted; this is intentional, so a held button is seen as a press.
- Counters never wrap: `rst_cnt` saturates at 0, and the debounce counter resets at `DEBOUNCE_CYCLES-1`.

## Structure
- Package `board_io_pkg`:
  - Function `cnt_width(n)`, returning max(1, `$clog2(n)`).
  - Constant `DEFAULT_RESET_CYCLES` = 16.
- Sub-module `input_conditioner_channel`:
  - Contains one bit of synchroniser, polarity correction, debounce and edge detection.
  - Parameters: `SYNC_STAGES`, `ACTIVE_LOW`, `DEBOUNCE_CYCLES`.
  - Instantiated `NUM_INPUTS` times in a generate loop.
- The reset stretcher stays inline in `board_input_conditioner`.

## Test plan
- Power-up with defaults, `reset`=0 -> `sys_reset`=1 for exactly 16 cycles, then 0; `level`/`rise`/`fall` all 0 throughout.
- `reset` pulsed for 1 cycle at cycle 40, `RESET_CYCLES`=16 -> `sys_reset` high on cycles 41..56, low at 57; `reset` re-pulsed at cycle 50 -> `sys_reset` stays high until cycle 66.
- `NUM_INPUTS`=2, mask=2'b01:
  - `raw_in[0]` driven 1→0 at cycle 100 -> `level[0]`=1 and `rise[0]`=1 for one cycle after edge 104 (S=3, D=1).
  - `raw_in[1]` driven 0→1 at cycle 100 -> same response on bit 1.
- `DEBOUNCE_CYCLES`=8:
  - 5-cycle active glitch -> no `level` change, no pulse.
  - 20-cycle hold -> `level` high 11 edges after the sampling edge, `rise` single pulse.
  - Release -> single `fall` pulse.
- Pin held active through a runtime `reset` -> `level` forced 0 while `sys_reset`=1; after release, `rise` pulse 4 edges after `sys_reset` falls.
